// File: rtl/riscv_pkg.sv
// Shared RV64I pipeline types and constants.
package riscv_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries for ID.
// Flush wins over push; push into a full FIFO is accepted only with a same-cycle pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  input  logic          flush,
  output T              head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr];

  // Storage: no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues in-order word fetches, buffers responses for ID and
// drops stale responses after a redirect using an outstanding/discard credit scheme.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_id_valid,
  output logic [ILEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] pc, rsp_pc, tgt;
  logic [CW-1:0]   outstanding, discard, fifo_count, out_next;
  logic [CW:0]     inflight, out_sum;
  logic            req_hs, rsp_ret, push, pop, fifo_empty, fifo_full;
  fetch_entry_t    head;
  logic            unused_ok;

  assign tgt       = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_ok = ^{redirect_pc[1:0], fifo_full};

  // Credit check on registered counts only, so a granted request always has a FIFO slot.
  assign inflight       = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && (inflight < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid && imem_req_ready;

  // A response always retires one outstanding request; the guard keeps the counter sane
  // if memory ever misbehaves.
  assign rsp_ret  = imem_rsp_valid && (outstanding != '0);
  assign out_sum  = {1'b0, outstanding} + (CW+1)'(req_hs) - (CW+1)'(rsp_ret);
  assign out_next = out_sum[CW-1:0];

  assign push = imem_rsp_valid && (discard == '0) && !redirect_valid;
  assign pop  = if_id_valid && id_ready && !redirect_valid;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{pc: rsp_pc, instr: imem_rsp_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign if_id_valid = !fifo_empty;
  assign if_id_instr = fifo_empty ? NOP_INSTR : head.instr;
  assign if_id_pc    = fifo_empty ? '0 : head.pc;

  // PC / response-PC and credit counters; redirect overrides normal bookkeeping and turns
  // everything still in flight (including a request accepted this cycle) into discards.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      pc          <= tgt;
      rsp_pc      <= tgt;
      outstanding <= out_next;
      discard     <= out_next;
    end else begin
      if (req_hs) pc <= pc + 64'd4;
      if (push)   rsp_pc <= rsp_pc + 64'd4;
      outstanding <= out_next;
      if (rsp_ret && discard != '0) discard <= discard - 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model with configurable latency, ID-side
// monitor feeding an observed queue, and per-scenario expected queues.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rdy = 1'b1;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_ready = 1'b1;
  logic        imem_req_valid, if_id_valid;
  logic [63:0] imem_req_addr, if_id_pc;
  logic [31:0] if_id_instr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; int cyc; } obs_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;
  mreq_t       mq[$];
  obs_t        obs_q[$];
  exp_t        exp_q[$];
  logic [63:0] req_log[$];

  fetch_stage #(.RESET_PC(64'h0), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (mem_rdy),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0003;
  endfunction

  // Memory model (in-order, fixed latency) and ID-side monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mq.delete();
    end else if (imem_req_valid && mem_rdy) begin
      mq.push_back('{imem_req_addr, cyc + 1 + lat});
      req_log.push_back(imem_req_addr);
    end
    if (!rst && mq.size() > 0 && mq[0].due <= cyc + 2) begin
      rsp_valid <= 1'b1;
      rsp_data  <= mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      rsp_valid <= 1'b0;
    end
    if (!rst && if_id_valid && id_ready && !redirect_valid)
      obs_q.push_back('{if_id_pc, if_id_instr, cyc + 1});
  end

  task automatic push_exp(input logic [63:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back('{start + 64'(4 * i), mem_word(start + 64'(4 * i))});
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int k = 0;
    while (obs_q.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic do_reset(input logic rdy, input int l);
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; id_ready = rdy; lat = l;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    req_log.delete();
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; id_ready = 1'b1; lat = 1;
    @(negedge clk);
    total += 4;
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    if (if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%b exp=0", if_id_valid); end
    if (if_id_instr !== NOP_INSTR) begin bad++; $display("FAIL reset_id_instr got=%h exp=%h", if_id_instr, NOP_INSTR); end
    if (if_id_pc !== 64'h0) begin bad++; $display("FAIL reset_id_pc got=%h exp=0", if_id_pc); end
    rst = 1'b0;
    obs_q.delete();
    req_log.delete();
  endtask

  task automatic test_stream;
    bit ok;
    push_exp(64'h0, 6);
    wait_obs(6, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stream_timeout got=%0d exp=6", obs_q.size()); end
    else begin
      total++;
      if (obs_q[1].cyc - obs_q[0].cyc !== 1) begin
        bad++; $display("FAIL stream_b2b got=%0d exp=1", obs_q[1].cyc - obs_q[0].cyc);
      end
      for (int i = 0; i < 3; i++) begin
        total++;
        if (req_log[i] !== 64'(4 * i)) begin bad++; $display("FAIL stream_req[%0d] got=%h exp=%h", i, req_log[i], 64'(4 * i)); end
      end
      for (int i = 0; i < 6; i++) begin
        exp_t e; obs_t o;
        e = exp_q.pop_front(); o = obs_q.pop_front();
        total++;
        if (o.pc !== e.pc || o.instr !== e.instr) begin
          bad++; $display("FAIL stream[%0d] got pc=%h instr=%h exp pc=%h instr=%h", i, o.pc, o.instr, e.pc, e.instr);
        end
      end
    end
  endtask

  task automatic test_stall;
    bit ok;
    do_reset(1'b0, 1);
    repeat (10) @(negedge clk);
    total += 3;
    if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0) begin bad++; $display("FAIL stall_head got v=%b pc=%h exp v=1 pc=0", if_id_valid, if_id_pc); end
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid got=%b exp=0", imem_req_valid); end
    if (req_log.size() !== 2) begin bad++; $display("FAIL stall_req_count got=%0d exp=2", req_log.size()); end
    id_ready = 1'b1;
    push_exp(64'h0, 6);
    wait_obs(6, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_timeout got=%0d exp=6", obs_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o.pc !== e.pc || o.instr !== e.instr) begin
        bad++; $display("FAIL stall[%0d] got pc=%h instr=%h exp pc=%h instr=%h", i, o.pc, o.instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_redirect_inflight;
    bit ok;
    int k = 0;
    do_reset(1'b1, 3);
    while (req_log.size() < 2 && k < 50) begin @(negedge clk); k++; end
    total++;
    if (req_log.size() < 2) begin bad++; $display("FAIL redir_setup got=%0d exp=2", req_log.size()); end
    redirect_valid = 1'b1; redirect_pc = 64'h1000;
    obs_q.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
    total++;
    if (if_id_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b exp=0", if_id_valid); end
    push_exp(64'h1000, 3);
    wait_obs(3, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL redir_timeout got=%0d exp=3", obs_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o.pc !== e.pc || o.instr !== e.instr) begin
        bad++; $display("FAIL redir[%0d] got pc=%h instr=%h exp pc=%h instr=%h", i, o.pc, o.instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_redirect_same_cycle;
    bit ok;
    bit found = 1'b0;
    do_reset(1'b1, 1);
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk); #1;
      if (imem_req_valid && mem_rdy && rsp_valid) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL same_setup got=0 exp=1"); end
    redirect_valid = 1'b1; redirect_pc = 64'h2003;
    obs_q.delete();
    req_log.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
    push_exp(64'h2000, 3);
    wait_obs(3, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL same_timeout got=%0d exp=3", obs_q.size()); end
    else begin
      total++;
      if (req_log[1] !== 64'h2000) begin bad++; $display("FAIL same_fetch_addr got=%h exp=2000", req_log[1]); end
      for (int i = 0; i < 3; i++) begin
        exp_t e; obs_t o;
        e = exp_q.pop_front(); o = obs_q.pop_front();
        total++;
        if (o.pc !== e.pc || o.instr !== e.instr) begin
          bad++; $display("FAIL same[%0d] got pc=%h instr=%h exp pc=%h instr=%h", i, o.pc, o.instr, e.pc, e.instr);
        end
      end
    end
  endtask

  task automatic test_double_redirect;
    bit ok;
    do_reset(1'b1, 3);
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    obs_q.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    push_exp(64'h200, 4);
    wait_obs(4, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL dbl_timeout got=%0d exp=4", obs_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o.pc !== e.pc || o.instr !== e.instr) begin
        bad++; $display("FAIL dbl[%0d] got pc=%h instr=%h exp pc=%h instr=%h", i, o.pc, o.instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_reset_full;
    bit ok;
    int k = 0;
    do_reset(1'b0, 1);
    repeat (8) @(negedge clk);
    total++;
    if (if_id_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL rfull_setup got v=%b req=%b exp v=1 req=0", if_id_valid, imem_req_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    total += 3;
    if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rfull_valid got=%b exp=0", if_id_valid); end
    if (if_id_instr !== NOP_INSTR) begin bad++; $display("FAIL rfull_instr got=%h exp=%h", if_id_instr, NOP_INSTR); end
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rfull_req got=%b exp=0", imem_req_valid); end
    rst = 1'b0; id_ready = 1'b1;
    obs_q.delete();
    req_log.delete();
    while (req_log.size() < 1 && k < 20) begin @(negedge clk); k++; end
    total++;
    if (req_log.size() < 1 || req_log[0] !== 64'h0) begin
      bad++; $display("FAIL rfull_first_req got=%h exp=0", (req_log.size() > 0) ? req_log[0] : 64'hx);
    end
    push_exp(64'h0, 2);
    wait_obs(2, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rfull_timeout got=%0d exp=2", obs_q.size()); end
    else for (int i = 0; i < 2; i++) begin
      exp_t e; obs_t o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o.pc !== e.pc || o.instr !== e.instr) begin
        bad++; $display("FAIL rfull[%0d] got pc=%h instr=%h exp pc=%h instr=%h", i, o.pc, o.instr, e.pc, e.instr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_double_redirect();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
